// File: rtl/product_accumulator.sv
// product_accumulator: sums N_TERMS unsigned 8-bit products into an ACC_W-bit
// result and hands the result downstream with a valid/ready handshake.
// Build option: define ACC_SATURATE_EN to clamp overflow at 2^ACC_W-1 and flag
// it on sat; leave it undefined to wrap modulo 2^ACC_W with sat tied low.
module product_accumulator #(
    parameter int unsigned N_TERMS = 4,
    parameter int unsigned ACC_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [7:0]       prod_in,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] sum_out,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic             sat
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StHold  = 2'd2
    } state_e;

    localparam int unsigned PadW    = ACC_W - 7;
    localparam logic [7:0]  LastCnt = 8'(N_TERMS - 1);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic               sum_valid_q, sum_valid_d;
    logic               sat_q, sat_d;
    logic               ready_q;

    logic               beat;
    logic               last_beat;
    logic [ACC_W:0]     add_full;
    logic [ACC_W-1:0]   acc_next;
    logic               ovf_hit;

    // Ready only once out of reset, never while a result is waiting, never during clr.
    assign prod_ready = ready_q & (state_q != StHold) & ~clr;
    assign beat       = prod_valid & prod_ready;
    assign last_beat  = (cnt_q == LastCnt);

    assign sum_out    = sum_q;
    assign sum_valid  = sum_valid_q;
    assign sat        = sat_q;

    // Accumulator adder with one extra bit so overflow is visible as a carry out.
    always_comb begin
        add_full = {1'b0, acc_q} + {{PadW{1'b0}}, prod_in};
`ifdef ACC_SATURATE_EN
        ovf_hit  = add_full[ACC_W];
        acc_next = add_full[ACC_W] ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
`else
        ovf_hit  = 1'b0;
        acc_next = add_full[ACC_W-1:0];
`endif
    end

    // Next-state logic: clr wins over any beat or result handshake.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        sum_d       = sum_q;
        sum_valid_d = sum_valid_q;
        sat_d       = sat_q;

        if (clr) begin
            state_d     = StIdle;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            sum_valid_d = 1'b0;
            sat_d       = 1'b0;
        end else begin
            case (state_q)
                StIdle, StAccum: begin
                    if (beat) begin
                        acc_d = acc_next;
                        cnt_d = 8'(cnt_q + 8'd1);
                        ovf_d = ovf_q | ovf_hit;
                        if (last_beat) begin
                            // Result is registered on the same edge as the final beat.
                            sum_d       = acc_next;
                            sum_valid_d = 1'b1;
                            sat_d       = ovf_q | ovf_hit;
                            state_d     = StHold;
                        end else begin
                            state_d = StAccum;
                        end
                    end
                end
                StHold: begin
                    if (sum_valid_q && sum_ready) begin
                        state_d     = StIdle;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        sum_valid_d = 1'b0;
                        sat_d       = 1'b0;
                    end
                end
                default: begin
                    state_d     = StIdle;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    sum_valid_d = 1'b0;
                    sat_d       = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers; reset discards any partial group or pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            sat_q       <= sat_d;
        end
    end

    // Holds prod_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Randomised scoreboard bench for product_accumulator. A reference model
// pushes expected group results into a queue; a negedge monitor pops and
// compares whenever the DUT raises sum_valid. A second instance
// (ACC_W=10, N_TERMS=8) exercises overflow handling.
module tb_product_accumulator;

    localparam int unsigned NT = 4;
    localparam int unsigned AW = 16;
`ifdef ACC_SATURATE_EN
    localparam bit SatMode = 1'b1;
`else
    localparam bit SatMode = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic [7:0]    prod_in;
    logic          prod_valid;
    logic          prod_ready;
    logic [AW-1:0] sum_out;
    logic          sum_valid;
    logic          sum_ready;
    logic          sat;

    logic          c2_clr;
    logic [7:0]    p2_in;
    logic          p2_valid;
    logic          p2_ready;
    logic [9:0]    s2_out;
    logic          s2_valid;
    logic          s2_ready;
    logic          s2_sat;

    product_accumulator #(.N_TERMS(NT), .ACC_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .prod_in(prod_in),
        .prod_valid(prod_valid), .prod_ready(prod_ready), .sum_out(sum_out),
        .sum_valid(sum_valid), .sum_ready(sum_ready), .sat(sat)
    );

    product_accumulator #(.N_TERMS(8), .ACC_W(10)) dut2 (
        .clk(clk), .rst_n(rst_n), .clr(c2_clr), .prod_in(p2_in),
        .prod_valid(p2_valid), .prod_ready(p2_ready), .sum_out(s2_out),
        .sum_valid(s2_valid), .sum_ready(s2_ready), .sat(s2_sat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected group result from the plain arithmetic total of its beats.
    function automatic logic [63:0] ref_sum(input longint unsigned total, input int unsigned w);
        longint unsigned maxv = (64'd1 << w) - 64'd1;
        if (SatMode) return (total > maxv) ? maxv : total;
        return total & maxv;
    endfunction

    function automatic logic ref_sat(input longint unsigned total, input int unsigned w);
        longint unsigned maxv = (64'd1 << w) - 64'd1;
        return SatMode && (total > maxv);
    endfunction

    typedef struct {
        logic [63:0] sum;
        logic        s;
    } exp_t;

    exp_t            sb[$];
    bit              m_rdy;
    bit              m_hold;
    int              m_cnt;
    longint unsigned m_total;

    // Reference model: counts accepted beats and totals them per group.
    always @(posedge clk or negedge rst_n) begin : model
        bit              hold_n;
        int              cnt_n;
        longint unsigned tot_n;
        if (!rst_n) begin
            m_rdy   <= 1'b0;
            m_hold  <= 1'b0;
            m_cnt   <= 0;
            m_total <= 0;
            sb.delete();
        end else begin
            hold_n = m_hold;
            cnt_n  = m_cnt;
            tot_n  = m_total;
            if (clr) begin
                hold_n = 1'b0;
                cnt_n  = 0;
                tot_n  = 0;
            end else if (m_hold) begin
                if (sum_ready) hold_n = 1'b0;
            end else if (prod_valid && m_rdy) begin
                tot_n = tot_n + longint'(prod_in);
                cnt_n = cnt_n + 1;
                if (cnt_n == NT) begin
                    sb.push_back('{ref_sum(tot_n, AW), ref_sat(tot_n, AW)});
                    hold_n = 1'b1;
                    cnt_n  = 0;
                    tot_n  = 0;
                end
            end
            m_hold  <= hold_n;
            m_cnt   <= cnt_n;
            m_total <= tot_n;
            m_rdy   <= 1'b1;
        end
    end

    logic          sv_prev = 1'b0;
    logic [63:0]   held_sum;
    logic          held_sat;

    // Monitor: handshake flags every cycle, result popped on sum_valid rise.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sv_prev <= 1'b0;
        end else begin
            chk("prod_ready", prod_ready, m_rdy && !m_hold && !clr);
            chk("sum_valid", sum_valid, m_hold);
            if (sum_valid && !sv_prev) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_result: got sum_out 0x%0h, expected no result", sum_out);
                end else begin
                    e = sb.pop_front();
                    chk("sum_out", sum_out, e.sum);
                    chk("sat", sat, e.s);
                    held_sum <= e.sum;
                    held_sat <= e.s;
                end
            end else if (sum_valid) begin
                chk("sum_out_stable", sum_out, held_sum);
                chk("sat_stable", sat, held_sat);
            end
            sv_prev <= sum_valid;
        end
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic c, input logic r);
        prod_valid = v;
        prod_in    = d;
        clr        = c;
        sum_ready  = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        longint unsigned tot;
        rst_n = 1'b0; clr = 1'b0; prod_valid = 1'b0; prod_in = '0; sum_ready = 1'b0;
        c2_clr = 1'b0; p2_valid = 1'b0; p2_in = '0; s2_ready = 1'b1;
        #1;
        chk("reset_prod_ready", prod_ready, 0);
        chk("reset_sum_valid", sum_valid, 0);
        chk("reset_sum_out", sum_out, 0);
        chk("reset_sat", sat, 0);
        #20;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("ready_before_first_edge", prod_ready, 0);
        drive(0, 8'h00, 0, 1);
        chk("ready_after_first_edge", prod_ready, 1);

        // Basic group with sum_ready high.
        drive(1, 8'h0F, 0, 1);
        drive(1, 8'hE1, 0, 1);
        drive(1, 8'h01, 0, 1);
        drive(1, 8'h10, 0, 1);
        chk("basic_valid", sum_valid, 1);
        chk("basic_sum", sum_out, 16'h0101);
        drive(0, 8'h00, 0, 1);
        chk("basic_valid_one_cycle", sum_valid, 0);
        chk("basic_back_to_idle", prod_ready, 1);

        // Back-pressure: result held for 5 cycles, offered beats refused.
        tot = 0;
        for (int i = 0; i < 4; i++) begin
            prod_in = 8'($urandom);
            tot = tot + longint'(prod_in);
            drive(1, prod_in, 0, 0);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'($urandom), 0, 0);
            chk("hold_valid", sum_valid, 1);
            chk("hold_ready_low", prod_ready, 0);
            chk("hold_sum", sum_out, ref_sum(tot, AW));
        end
        drive(0, 8'h00, 0, 1);
        chk("release_valid", sum_valid, 0);
        chk("release_ready", prod_ready, 1);

        // clr aborts a partial group.
        drive(1, 8'h10, 0, 1);
        drive(1, 8'h20, 0, 1);
        drive(0, 8'h00, 1, 1);
        for (int i = 0; i < 4; i++) drive(1, 8'h01, 0, 1);
        chk("clr_sum", sum_out, 16'h0004);
        chk("clr_valid", sum_valid, 1);
        drive(0, 8'h00, 0, 1);

        // Gaps change nothing; a beat coincident with clr is discarded.
        drive(1, 8'h40, 0, 1);
        drive(0, 8'h77, 0, 1);
        drive(1, 8'h55, 1, 1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 8'hFF, 0, 1);
            drive(1, 8'h03, 0, 1);
        end
        chk("gap_sum", sum_out, 16'h000C);
        drive(0, 8'h00, 0, 1);

        // Overflow behaviour on the narrow instance.
        chk("dut2_ready", p2_ready, 1);
        for (int i = 0; i < 8; i++) begin
            p2_valid = 1'b1;
            p2_in    = 8'hE1;
            @(posedge clk);
            #1;
        end
        p2_valid = 1'b0;
        for (int i = 0; i < 20 && !s2_valid; i++) begin
            @(posedge clk);
            #1;
        end
        chk("dut2_valid", s2_valid, 1);
        chk("dut2_sum", s2_out, ref_sum(8 * 225, 10));
        chk("dut2_sat", s2_sat, ref_sat(8 * 225, 10));
        @(posedge clk);
        #1;

        // Asynchronous reset in mid-group.
        for (int i = 0; i < 3; i++) drive(1, 8'h33, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_prod_ready", prod_ready, 0);
        chk("async_rst_sum_valid", sum_valid, 0);
        chk("async_rst_sum_out", sum_out, 0);
        chk("async_rst_sat", sat, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_rst_ready_low", prod_ready, 0);
        drive(0, 8'h00, 0, 1);
        for (int i = 0; i < 4; i++) drive(1, 8'h02, 0, 1);
        chk("post_rst_sum", sum_out, 16'h0008);
        chk("post_rst_valid", sum_valid, 1);
        drive(0, 8'h00, 0, 1);

        // Random traffic: gaps, clr pulses, random back-pressure.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 2) != 0), 8'($urandom),
                  ($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)));
        end
        drive(0, 8'h00, 0, 1);
        drive(0, 8'h00, 0, 1);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter N_TERMS, default 4, meaning products summed per result (legal 1..255).
REQ-002 SHALL have parameter ACC_W, default 16, meaning accumulator/result width (legal 8..32).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clr  input  1  synchronous abort of the current group.
REQ-006 SHALL have port prod_in  input  8  unsigned product from the upstream 4x4 multiplier stage.
REQ-007 SHALL have port prod_valid  input  1  prod_in is valid this cycle.
REQ-008 SHALL have port prod_ready  output  1  block accepts prod_in this cycle.
REQ-009 SHALL have port sum_out  output  ACC_W  accumulated result.
REQ-010 SHALL have port sum_valid  output  1  sum_out holds a completed result.
REQ-011 SHALL have port sum_ready  input  1  downstream consumes sum_out.
REQ-012 SHALL have port sat  output  1  completed result was saturated.

Function
REQ-013 SHALL implement FSM states IDLE (acc=0, cnt=0), ACCUM, HOLD.
REQ-014 SHALL accept a beat only when prod_valid & prod_ready at a clk edge; prod_ready=1 in IDLE/ACCUM, 0 in HOLD and whenever clr=1.
REQ-015 SHALL, per accepted beat, add zero-extended prod_in to acc and increment cnt; IDLE moves to ACCUM on first beat.
REQ-016 SHALL, on the N_TERMS-th accepted beat, load sum_out with acc+prod_in, assert sum_valid and enter HOLD on that same edge (result visible the cycle after the last beat); N_TERMS=1 goes IDLE->HOLD directly.
REQ-017 SHALL hold sum_out, sat and sum_valid stable in HOLD until sum_valid & sum_ready, then clear acc/cnt, deassert sum_valid and return to IDLE on that edge.
REQ-018 SHALL ignore cycles with prod_valid=0 (no acc/cnt change, no timeout).
REQ-019 SHALL, when clr=1 at an edge, return to IDLE with acc=0, cnt=0, sum_valid=0, sat=0 in any state; clr overrides a simultaneous beat or sum handshake (beat discarded, result dropped).
REQ-020 SHALL treat arithmetic as unsigned ACC_W bits; overflow handling per REQ-026/027.
REQ-021 SHALL keep sum_out at its last value outside HOLD (only sum_valid qualifies it).

Reset
REQ-022 SHALL, while rst_n=0, force immediately (asynchronous): state=IDLE, acc=0, cnt=0, sum_out=0, sum_valid=0, sat=0, prod_ready=0.
REQ-023 SHALL drive prod_ready=1 from the first clk edge after rst_n deasserts.
REQ-024 SHALL discard any partial group or pending result on reset mid-operation; next group starts from zero.

Configuration
REQ-025 SHALL use macro ACC_SATURATE_EN to select overflow behaviour.
REQ-026 SHALL, with ACC_SATURATE_EN defined, clamp acc at 2^ACC_W-1 and latch sat=1 for that group's result; sat clears on leaving HOLD, clr or reset.
REQ-027 SHALL, without ACC_SATURATE_EN, wrap modulo 2^ACC_W and tie sat to 0.

Verification
REQ-028 SHALL cover: defaults, beats 0x0F,0xE1,0x01,0x10 with sum_ready=1 -> sum_out=0x0101, sum_valid high exactly one cycle, then IDLE.
REQ-029 SHALL cover: completed group, sum_ready=0 for 5 cycles -> sum_valid=1, sum_out stable, prod_ready=0 throughout; sum_ready=1 -> prod_ready=1 next cycle.
REQ-030 SHALL cover: beats 0x10,0x20, clr pulse, then 4 beats of 0x01 -> sum_out=0x0004.
REQ-031 SHALL cover: ACC_W=10, N_TERMS=8, eight beats 0xE1 -> with ACC_SATURATE_EN sum_out=0x3FF, sat=1; without, sum_out=0x308, sat=0.
REQ-032 SHALL cover: rst_n low between edges after 3 beats -> all outputs 0 immediately; after release, 4 beats of 0x02 -> sum_out=0x0008.
REQ-033 SHALL cover: beats interleaved with random prod_valid=0 gaps and clr+prod_valid in the same cycle -> gaps change nothing, clr-cycle beat not counted.
